// File: rtl/tlc_pkg.sv
// tlc_pkg: shared state type, default phase timings and lamp decode for the traffic light controller
package tlc_pkg;

    typedef enum logic [1:0] {GREEN, YELLOW, RED, WALK} tlc_state_t;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
        logic walk;
    } lamps_t;

    localparam int DEF_GREEN_TIME  = 6;
    localparam int DEF_MIN_GREEN   = 2;
    localparam int DEF_YELLOW_TIME = 2;
    localparam int DEF_RED_TIME    = 2;
    localparam int DEF_WALK_TIME   = 3;
    localparam int DEF_CNT_W       = 8;

    function automatic lamps_t decode_lamps(input tlc_state_t s);
        return '{red: (s == RED) || (s == WALK), yellow: s == YELLOW, green: s == GREEN, walk: s == WALK};
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// tlc_phase_timer: cycles-in-phase counter, cleared on state change, flags the last cycle of a phase
module tlc_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic [CNT_W:0]   limit_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             expired_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clear_i ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;

    assign cnt_o     = cnt_q;
    assign expired_o = {1'b0, cnt_q} == limit_i - (CNT_W+1)'(1);
endmodule

// File: rtl/traffic_light_controller.sv
// traffic_light_controller: GREEN/YELLOW/RED cycle with a latched pedestrian request that inserts WALK
module traffic_light_controller
    import tlc_pkg::*;
#(
    parameter int GREEN_TIME  = DEF_GREEN_TIME,
    parameter int MIN_GREEN   = DEF_MIN_GREEN,
    parameter int YELLOW_TIME = DEF_YELLOW_TIME,
    parameter int RED_TIME    = DEF_RED_TIME,
    parameter int WALK_TIME   = DEF_WALK_TIME,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic ped_button,
    output logic red,
    output logic yellow,
    output logic green,
    output logic ped_walk
);
    if (MIN_GREEN < 1 || MIN_GREEN > GREEN_TIME || YELLOW_TIME < 1 || RED_TIME < 1 || WALK_TIME < 1 ||
        GREEN_TIME > (1 << CNT_W) || YELLOW_TIME > (1 << CNT_W) || RED_TIME > (1 << CNT_W) ||
        WALK_TIME > (1 << CNT_W)) begin : g_bad_params
        $error("traffic_light_controller: illegal timing parameters");
    end

    tlc_state_t     state_q, state_d;
    logic           ped_req_q, ped_req_d;
    logic [CNT_W:0] limit;
    logic [CNT_W-1:0] t;
    logic           expired, min_green_done;
    lamps_t         lamps;

    always_comb limit = state_q == GREEN  ? (CNT_W+1)'(GREEN_TIME)  :
                        state_q == YELLOW ? (CNT_W+1)'(YELLOW_TIME) :
                        state_q == RED    ? (CNT_W+1)'(RED_TIME)    : (CNT_W+1)'(WALK_TIME);

    tlc_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_d != state_q),
        .limit_i   (limit),
        .cnt_o     (t),
        .expired_o (expired)
    );

    assign min_green_done = {1'b0, t} >= (CNT_W+1)'(MIN_GREEN - 1);

    always_ff @(posedge clk) begin
        state_q   <= reset ? GREEN : state_d;
        ped_req_q <= reset ? 1'b0 : ped_req_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GREEN:  state_d = (expired || (ped_req_q && min_green_done)) ? YELLOW : GREEN;
            YELLOW: state_d = expired ? RED : YELLOW;
            RED:    state_d = expired ? (ped_req_q ? WALK : GREEN) : RED;
            WALK:   state_d = expired ? GREEN : WALK;
        endcase
    end

    // Entering WALK clears the request even if the button is pressed on that edge
    always_comb ped_req_d = state_q == WALK ? ped_req_q :
                            state_d == WALK ? 1'b0 : ped_req_q | ped_button;

    always_comb begin
        lamps    = decode_lamps(state_q);
        red      = lamps.red;
        yellow   = lamps.yellow;
        green    = lamps.green;
        ped_walk = lamps.walk;
    end
endmodule

// File: tb/tb_traffic_light_controller.sv
// tb_traffic_light_controller: directed vector table plus randomized run against a phase-duration model
module tb_traffic_light_controller;
    localparam int GT = 6, MG = 2, YT = 2, RT = 2, WT = 3;
    localparam logic [3:0] LG = 4'b0010, LY = 4'b0100, LR = 4'b1000, LW = 4'b1001;

    logic clk = 1'b0, reset = 1'b1, ped_button = 1'b0;
    logic red, yellow, green, ped_walk;
    int compared = 0, mismatched = 0;

    typedef struct {
        bit         rst;
        bit         btn;
        logic [3:0] exp;
        string      tag;
    } vec_t;
    vec_t vq[$];

    always #5 clk = ~clk;

    traffic_light_controller #(
        .GREEN_TIME(GT), .MIN_GREEN(MG), .YELLOW_TIME(YT), .RED_TIME(RT), .WALK_TIME(WT), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .ped_button(ped_button),
        .red(red), .yellow(yellow), .green(green), .ped_walk(ped_walk)
    );

    task automatic add(input string tag, input bit r, input bit b, input logic [3:0] e);
        vq.push_back('{rst: r, btn: b, exp: e, tag: tag});
    endtask

    task automatic add_n(input string tag, input int n, input bit b, input logic [3:0] e);
        repeat (n) add(tag, 1'b0, b, e);
    endtask

    task automatic check(input string tag, input int i, input logic [3:0] e);
        logic [3:0] got;
        got = {red, yellow, green, ped_walk};
        compared++;
        if (got !== e) begin
            mismatched++;
            $display("FAIL %s step %0d: got ryg_walk=%b want %b", tag, i, got, e);
        end
    endtask

    // Model: phase index with cycles already spent in it, compared against phase durations
    int  m_ph, m_age;
    bit  m_req;
    int  dur[4] = '{GT, YT, RT, WT};

    task automatic model_edge(input bit r, input bit b);
        int nph;
        if (r) begin
            m_ph = 0; m_age = 1; m_req = 0;
            return;
        end
        nph = m_ph;
        if (m_age == dur[m_ph] || (m_ph == 0 && m_req && m_age >= MG))
            nph = (m_ph == 0) ? 1 : (m_ph == 1) ? 2 : (m_ph == 2) ? (m_req ? 3 : 0) : 0;
        if (m_ph != 3) m_req = (nph == 3) ? 1'b0 : (m_req | b);
        m_age = (nph == m_ph) ? m_age + 1 : 1;
        m_ph = nph;
    endtask

    function automatic logic [3:0] model_lamps();
        return m_ph == 0 ? LG : m_ph == 1 ? LY : m_ph == 2 ? LR : LW;
    endfunction

    initial begin
        add("idle", 1, 0, LG); add_n("idle", 5, 0, LG); add_n("idle", 2, 0, LY);
        add_n("idle", 2, 0, LR); add_n("idle", 1, 0, LG);

        add("pulse", 1, 0, LG); add_n("pulse", 1, 0, LG); add_n("pulse", 1, 1, LG);
        add_n("pulse", 2, 0, LY); add_n("pulse", 2, 0, LR); add_n("pulse", 3, 0, LW);
        add_n("pulse", 1, 0, LG);

        add("held", 1, 0, LG); add_n("held", 1, 0, LG); add_n("held", 1, 1, LG);
        add_n("held", 2, 1, LY); add_n("held", 2, 1, LR); add_n("held", 3, 0, LW);
        add_n("held", 6, 0, LG); add_n("held", 2, 0, LY); add_n("held", 2, 0, LR);
        add_n("held", 1, 0, LG);

        add("walkpress", 1, 0, LG); add_n("walkpress", 1, 0, LG); add_n("walkpress", 1, 1, LG);
        add_n("walkpress", 2, 0, LY); add_n("walkpress", 2, 0, LR); add_n("walkpress", 1, 0, LW);
        add_n("walkpress", 2, 1, LW); add_n("walkpress", 1, 1, LG); add_n("walkpress", 5, 0, LG);
        add_n("walkpress", 2, 0, LY); add_n("walkpress", 2, 0, LR); add_n("walkpress", 1, 0, LG);

        add("yellowpress", 1, 0, LG); add_n("yellowpress", 5, 0, LG); add_n("yellowpress", 1, 0, LY);
        add_n("yellowpress", 1, 1, LY); add_n("yellowpress", 2, 0, LR); add_n("yellowpress", 3, 0, LW);
        add_n("yellowpress", 6, 0, LG); add_n("yellowpress", 2, 0, LY);

        add("rstwalk", 1, 0, LG); add_n("rstwalk", 1, 0, LG); add_n("rstwalk", 1, 1, LG);
        add_n("rstwalk", 2, 0, LY); add_n("rstwalk", 2, 0, LR); add_n("rstwalk", 1, 0, LW);
        add_n("rstwalk", 1, 1, LW); add("rstwalk", 1, 0, LG); add_n("rstwalk", 5, 0, LG);
        add_n("rstwalk", 2, 0, LY); add_n("rstwalk", 2, 0, LR); add_n("rstwalk", 1, 0, LG);

        add("rstreq", 1, 0, LG); add_n("rstreq", 1, 1, LG); add("rstreq", 1, 0, LG);
        add_n("rstreq", 5, 0, LG); add_n("rstreq", 2, 0, LY); add_n("rstreq", 2, 0, LR);
        add_n("rstreq", 1, 0, LG);

        add("mingreen", 1, 0, LG); add_n("mingreen", 1, 1, LG); add_n("mingreen", 2, 0, LY);
        add_n("mingreen", 2, 0, LR); add_n("mingreen", 3, 0, LW); add_n("mingreen", 1, 0, LG);

        add("redlast", 1, 0, LG); add_n("redlast", 5, 0, LG); add_n("redlast", 2, 0, LY);
        add_n("redlast", 2, 0, LR); add_n("redlast", 1, 1, LG); add_n("redlast", 1, 0, LG);
        add_n("redlast", 2, 0, LY); add_n("redlast", 2, 0, LR); add_n("redlast", 3, 0, LW);
        add_n("redlast", 1, 0, LG);

        foreach (vq[i]) begin
            @(negedge clk);
            reset = vq[i].rst;
            ped_button = vq[i].btn;
            @(posedge clk);
            #1 check(vq[i].tag, i, vq[i].exp);
        end

        begin
            int hold = 0;
            bit r, b;
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk);
                r = (i == 0) || ($urandom_range(149) == 0);
                if (hold > 0) begin
                    b = 1'b1;
                    hold--;
                end else if ($urandom_range(11) == 0) begin
                    b = 1'b1;
                    hold = $urandom_range(5);
                end else
                    b = 1'b0;
                reset = r;
                ped_button = b;
                @(posedge clk);
                model_edge(r, b);
                #1 check("random", i, model_lamps());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
